// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter and F/D pipeline register for the five-stage MIPS pipeline.
// Selects PC+4 or the D-stage redirect target and launches the fetched word into D.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        D_flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_PC,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] F_PC,
  output logic        F_AdEL,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_valid,
  output logic        D_AdEL,
  output logic [31:0] fetch_cnt
);

  logic [31:0] f_pc_q,      f_pc_d;
  logic [31:0] d_pc_q,      d_pc_d;
  logic [31:0] d_instr_q,   d_instr_d;
  logic        d_valid_q,   d_valid_d;
  logic        d_adel_q,    d_adel_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        f_adel;

  assign f_adel = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IM_BASE) || (f_pc_q > IM_LIMIT);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latch).
    f_pc_d      = f_pc_q;
    d_pc_d      = d_pc_q;
    d_instr_d   = d_instr_q;
    d_valid_d   = d_valid_q;
    d_adel_d    = d_adel_q;
    fetch_cnt_d = fetch_cnt_q;
    // A stall freezes everything: redirect operands are stale and a flush must not drop the held D instruction.
    if (!stall) begin
      f_pc_d = redirect_en ? redirect_PC : f_pc_q + 32'd4;
      d_pc_d = f_pc_q;
      if (D_flush) begin
        d_instr_d = '0;
        d_valid_d = 1'b0;
        d_adel_d  = 1'b0;
      end else begin
        // A bad fetch address still launches, as a nop tagged with the address error.
        d_instr_d   = f_adel ? '0 : i_inst_rdata;
        d_valid_d   = 1'b1;
        d_adel_d    = f_adel;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_q      <= RESET_PC;
      d_pc_q      <= '0;
      d_instr_q   <= '0;
      d_valid_q   <= 1'b0;
      d_adel_q    <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      f_pc_q      <= f_pc_d;
      d_pc_q      <= d_pc_d;
      d_instr_q   <= d_instr_d;
      d_valid_q   <= d_valid_d;
      d_adel_q    <= d_adel_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign F_PC        = f_pc_q;
  assign i_inst_addr = f_pc_q;
  assign F_AdEL      = f_adel;
  assign D_PC        = d_pc_q;
  assign D_Instr     = d_instr_q;
  assign D_valid     = d_valid_q;
  assign D_AdEL      = d_adel_q;
  assign fetch_cnt   = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized traffic
// compared against a behavioural pipeline model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT = 32'h0000_6FFC;
  localparam logic [31:0] PATTERN  = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, D_flush, redirect_en;
  logic [31:0] redirect_PC;
  logic [31:0] i_inst_addr, i_inst_rdata;
  logic [31:0] F_PC, D_PC, D_Instr, fetch_cnt;
  logic        F_AdEL, D_valid, D_AdEL;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_fpc, m_dpc, m_dinstr, m_cnt;
  logic        m_dvalid, m_dadel;

  fetch_pc_unit #(.RESET_PC(RESET_PC), .IM_BASE(IM_BASE), .IM_LIMIT(IM_LIMIT)) dut (
    .clk(clk), .reset(reset), .stall(stall), .D_flush(D_flush),
    .redirect_en(redirect_en), .redirect_PC(redirect_PC),
    .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .F_PC(F_PC), .F_AdEL(F_AdEL), .D_PC(D_PC), .D_Instr(D_Instr),
    .D_valid(D_valid), .D_AdEL(D_AdEL), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ PATTERN;
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < IM_BASE) || (a > IM_LIMIT);
  endfunction

  task automatic model_reset();
    m_fpc = RESET_PC; m_dpc = 0; m_dinstr = 0; m_dvalid = 0; m_dadel = 0; m_cnt = 0;
  endtask

  // Drive one cycle of inputs, advance the model by the pipeline rules, then sample after the edge.
  task automatic tick(input logic st, input logic fl, input logic re, input logic [31:0] rp);
    logic [31:0] nf;
    logic        bad;
    stall = st; D_flush = fl; redirect_en = re; redirect_PC = rp;
    if (!st) begin
      nf  = re ? rp : m_fpc + 32'd4;
      bad = bad_addr(m_fpc);
      m_dpc = m_fpc;
      if (fl) begin
        m_dinstr = 0; m_dvalid = 0; m_dadel = 0;
      end else begin
        m_dinstr = bad ? 32'd0 : mem_word(m_fpc);
        m_dvalid = 1; m_dadel = bad; m_cnt = m_cnt + 1;
      end
      m_fpc = nf;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; stall = 0; D_flush = 0; redirect_en = 0; redirect_PC = 0;
    model_reset();
    #12;
    n_vec += 6;
    if (F_PC !== RESET_PC) begin n_err++; $display("FAIL reset_fpc got=%h exp=%h", F_PC, RESET_PC); end
    if (D_PC !== 0) begin n_err++; $display("FAIL reset_dpc got=%h exp=0", D_PC); end
    if (D_Instr !== 0) begin n_err++; $display("FAIL reset_dinstr got=%h exp=0", D_Instr); end
    if (D_valid !== 0) begin n_err++; $display("FAIL reset_dvalid got=%b exp=0", D_valid); end
    if (D_AdEL !== 0) begin n_err++; $display("FAIL reset_dadel got=%b exp=0", D_AdEL); end
    if (fetch_cnt !== 0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", fetch_cnt); end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_sequential();
    for (int k = 1; k <= 3; k++) begin
      tick(0, 0, 0, 0);
      n_vec += 3;
      if (F_PC !== 32'h3000 + 4 * k) begin n_err++; $display("FAIL seq_fpc%0d got=%h exp=%h", k, F_PC, 32'h3000 + 4 * k); end
      if (D_PC !== 32'h3000 + 4 * (k - 1)) begin n_err++; $display("FAIL seq_dpc%0d got=%h exp=%h", k, D_PC, 32'h3000 + 4 * (k - 1)); end
      if (D_Instr !== ((32'h3000 + 4 * (k - 1)) ^ PATTERN)) begin n_err++; $display("FAIL seq_dinstr%0d got=%h", k, D_Instr); end
    end
    n_vec++;
    if (fetch_cnt !== 3) begin n_err++; $display("FAIL seq_cnt got=%0d exp=3", fetch_cnt); end
  endtask

  task automatic test_redirect();
    tick(0, 0, 0, 0);                       // F_PC -> 3010
    tick(0, 0, 1, 32'h3100);
    n_vec += 3;
    if (F_PC !== 32'h3100) begin n_err++; $display("FAIL redir_fpc got=%h exp=3100", F_PC); end
    if (D_PC !== 32'h3010) begin n_err++; $display("FAIL redir_delay_slot got=%h exp=3010", D_PC); end
    if (D_valid !== 1) begin n_err++; $display("FAIL redir_dvalid got=%b exp=1", D_valid); end
    tick(0, 0, 0, 0);
    n_vec += 2;
    if (D_PC !== 32'h3100) begin n_err++; $display("FAIL redir_dpc2 got=%h exp=3100", D_PC); end
    if (F_PC !== 32'h3104) begin n_err++; $display("FAIL redir_fpc2 got=%h exp=3104", F_PC); end
  endtask

  task automatic test_stall();
    logic [31:0] dpc0, cnt0;
    tick(0, 0, 1, 32'h3020);
    dpc0 = m_dpc; cnt0 = m_cnt;
    for (int k = 0; k < 2; k++) begin
      tick(1, 0, 1, 32'h4000);
      n_vec += 3;
      if (F_PC !== 32'h3020) begin n_err++; $display("FAIL stall_fpc got=%h exp=3020", F_PC); end
      if (D_PC !== dpc0) begin n_err++; $display("FAIL stall_dpc got=%h exp=%h", D_PC, dpc0); end
      if (fetch_cnt !== cnt0) begin n_err++; $display("FAIL stall_cnt got=%0d exp=%0d", fetch_cnt, cnt0); end
    end
    tick(0, 0, 1, 32'h4000);
    n_vec++;
    if (F_PC !== 32'h4000) begin n_err++; $display("FAIL stall_release_fpc got=%h exp=4000", F_PC); end
  endtask

  task automatic test_flush();
    logic [31:0] cnt0;
    tick(0, 0, 1, 32'h3030);
    cnt0 = m_cnt;
    tick(0, 1, 0, 0);
    n_vec += 5;
    if (D_valid !== 0) begin n_err++; $display("FAIL flush_dvalid got=%b exp=0", D_valid); end
    if (D_Instr !== 0) begin n_err++; $display("FAIL flush_dinstr got=%h exp=0", D_Instr); end
    if (D_PC !== 32'h3030) begin n_err++; $display("FAIL flush_dpc got=%h exp=3030", D_PC); end
    if (F_PC !== 32'h3034) begin n_err++; $display("FAIL flush_fpc got=%h exp=3034", F_PC); end
    if (fetch_cnt !== cnt0) begin n_err++; $display("FAIL flush_cnt got=%0d exp=%0d", fetch_cnt, cnt0); end
    tick(0, 0, 0, 0);                       // load a real instruction into D
    tick(1, 1, 0, 0);
    n_vec += 4;
    if (D_valid !== 1) begin n_err++; $display("FAIL flush_stall_dvalid got=%b exp=1", D_valid); end
    if (D_Instr !== (32'h3034 ^ PATTERN)) begin n_err++; $display("FAIL flush_stall_dinstr got=%h", D_Instr); end
    if (F_PC !== 32'h3038) begin n_err++; $display("FAIL flush_stall_fpc got=%h exp=3038", F_PC); end
    if (fetch_cnt !== cnt0 + 1) begin n_err++; $display("FAIL flush_stall_cnt got=%0d exp=%0d", fetch_cnt, cnt0 + 1); end
  endtask

  task automatic test_adel();
    tick(0, 0, 1, 32'h3002);
    n_vec += 2;
    if (F_AdEL !== 1) begin n_err++; $display("FAIL adel_mis_f got=%b exp=1", F_AdEL); end
    if (i_inst_addr !== 32'h3002) begin n_err++; $display("FAIL adel_mis_addr got=%h exp=3002", i_inst_addr); end
    tick(0, 0, 1, 32'h7000);
    n_vec += 5;
    if (D_AdEL !== 1) begin n_err++; $display("FAIL adel_mis_d got=%b exp=1", D_AdEL); end
    if (D_Instr !== 0) begin n_err++; $display("FAIL adel_mis_dinstr got=%h exp=0", D_Instr); end
    if (D_valid !== 1) begin n_err++; $display("FAIL adel_mis_dvalid got=%b exp=1", D_valid); end
    if (F_AdEL !== 1) begin n_err++; $display("FAIL adel_range_f got=%b exp=1", F_AdEL); end
    if (i_inst_addr !== 32'h7000) begin n_err++; $display("FAIL adel_range_addr got=%h exp=7000", i_inst_addr); end
    tick(0, 0, 1, 32'h6FFC);
    n_vec += 4;
    if (D_AdEL !== 1) begin n_err++; $display("FAIL adel_range_d got=%b exp=1", D_AdEL); end
    if (D_Instr !== 0) begin n_err++; $display("FAIL adel_range_dinstr got=%h exp=0", D_Instr); end
    if (F_AdEL !== 0) begin n_err++; $display("FAIL adel_limit_f got=%b exp=0", F_AdEL); end
    if (F_PC !== 32'h6FFC) begin n_err++; $display("FAIL adel_limit_fpc got=%h exp=6ffc", F_PC); end
    tick(0, 0, 1, 32'hFFFF_FFFC);
    n_vec += 2;
    if (D_AdEL !== 0) begin n_err++; $display("FAIL adel_limit_d got=%b exp=0", D_AdEL); end
    if (D_Instr !== (32'h6FFC ^ PATTERN)) begin n_err++; $display("FAIL adel_limit_dinstr got=%h", D_Instr); end
    tick(0, 0, 0, 0);
    n_vec += 2;
    if (F_PC !== 0) begin n_err++; $display("FAIL wrap_fpc got=%h exp=0", F_PC); end
    if (F_AdEL !== 1) begin n_err++; $display("FAIL wrap_adel got=%b exp=1", F_AdEL); end
  endtask

  task automatic test_async_reset();
    tick(0, 0, 1, 32'h3044);
    tick(0, 0, 0, 0);                       // F_PC = 3048, D holds 3044
    n_vec += 2;
    if (F_PC !== 32'h3048) begin n_err++; $display("FAIL areset_pre_fpc got=%h exp=3048", F_PC); end
    if (D_valid !== 1) begin n_err++; $display("FAIL areset_pre_dvalid got=%b exp=1", D_valid); end
    #2 reset = 1;
    #1;
    model_reset();
    n_vec += 4;
    if (F_PC !== RESET_PC) begin n_err++; $display("FAIL areset_fpc got=%h exp=%h", F_PC, RESET_PC); end
    if (D_valid !== 0) begin n_err++; $display("FAIL areset_dvalid got=%b exp=0", D_valid); end
    if (D_PC !== 0) begin n_err++; $display("FAIL areset_dpc got=%h exp=0", D_PC); end
    if (fetch_cnt !== 0) begin n_err++; $display("FAIL areset_cnt got=%0d exp=0", fetch_cnt); end
    #1 reset = 0;
    tick(0, 0, 0, 0);
    n_vec += 2;
    if (F_PC !== 32'h3004) begin n_err++; $display("FAIL areset_post_fpc got=%h exp=3004", F_PC); end
    if (D_PC !== 32'h3000) begin n_err++; $display("FAIL areset_post_dpc got=%h exp=3000", D_PC); end
  endtask

  task automatic test_random();
    logic        st, fl, re;
    logic [31:0] rp;
    for (int i = 0; i < 400; i++) begin
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 5) == 0);
      re = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       rp = $urandom;
        1:       rp = 32'h3000 + ($urandom_range(0, 4095) << 2) + $urandom_range(1, 3);
        default: rp = 32'h3000 + ($urandom_range(0, 4095) << 2);
      endcase
      tick(st, fl, re, rp);
      n_vec += 8;
      if (F_PC !== m_fpc) begin n_err++; $display("FAIL rnd%0d_fpc got=%h exp=%h", i, F_PC, m_fpc); end
      if (i_inst_addr !== m_fpc) begin n_err++; $display("FAIL rnd%0d_addr got=%h exp=%h", i, i_inst_addr, m_fpc); end
      if (F_AdEL !== bad_addr(m_fpc)) begin n_err++; $display("FAIL rnd%0d_fadel got=%b", i, F_AdEL); end
      if (D_PC !== m_dpc) begin n_err++; $display("FAIL rnd%0d_dpc got=%h exp=%h", i, D_PC, m_dpc); end
      if (D_Instr !== m_dinstr) begin n_err++; $display("FAIL rnd%0d_dinstr got=%h exp=%h", i, D_Instr, m_dinstr); end
      if (D_valid !== m_dvalid) begin n_err++; $display("FAIL rnd%0d_dvalid got=%b exp=%b", i, D_valid, m_dvalid); end
      if (D_AdEL !== m_dadel) begin n_err++; $display("FAIL rnd%0d_dadel got=%b exp=%b", i, D_AdEL, m_dadel); end
      if (fetch_cnt !== m_cnt) begin n_err++; $display("FAIL rnd%0d_cnt got=%0d exp=%0d", i, fetch_cnt, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_flush();
    test_adel();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage owner of the program counter in the five-stage MIPS pipeline.
- Holds F_PC and drives the instruction-memory address. Each cycle it accepts either the sequential PC+4 or the D-stage next-PC redirect value.
- Launches the fetched instruction into the F/D pipeline register.
- It is the consumer of the D-stage next-PC computation: it takes that computation's result and feeds F_PC back to it one stage later.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, lowest legal instruction address.
- IM_LIMIT, 32'h0000_6FFC, highest legal instruction address (inclusive).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; freezes the PC and the F/D register.
- D_flush  in  1  clears the F/D register to a bubble.
- redirect_en  in  1  the D-stage instruction is a jump or branch (PC select not PC+4).
- redirect_PC  in  32  target from the D-stage next-PC logic.
- i_inst_addr  out  32  instruction-memory address; equals F_PC.
- i_inst_rdata  in  32  combinational instruction-memory read data.
- F_PC  out  32  current fetch PC.
- F_AdEL  out  1  current fetch address is misaligned or out of range (combinational).
- D_PC  out  32  PC of the instruction in the D stage.
- D_Instr  out  32  instruction in the D stage.
- D_valid  out  1  D stage holds a real instruction.
- D_AdEL  out  1  registered F_AdEL for the D-stage instruction.
- fetch_cnt  out  32  count of instructions launched into D.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - F_PC = RESET_PC.
  - D_PC = 0, D_Instr = 0, D_valid = 0, D_AdEL = 0, fetch_cnt = 0.
- Combinational outputs:
  - i_inst_addr = F_PC.
  - F_AdEL = (F_PC[1:0] != 0) or F_PC < IM_BASE or F_PC > IM_LIMIT. Comparisons are unsigned.
- Next-PC selection:
  - nextF = redirect_en ? redirect_PC : F_PC + 4.
  - Addition is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0. That value is then flagged by F_AdEL, with no other special handling.
- Branch delay slot: a redirect does NOT squash the instruction currently in F. That instruction is the delay slot and proceeds into D normally.
- Per-rising-edge priority, with reset absent:
  1. stall=1:
     - F_PC holds; D_PC, D_Instr, D_valid, D_AdEL hold; fetch_cnt holds.
     - redirect_en is ignored, because D-stage operands are stale during a stall.
     - D_flush is also ignored: a stalled D instruction must not be lost.
  2. stall=0, D_flush=1:
     - F_PC <= nextF.
     - D_Instr <= 0, D_PC <= F_PC, D_valid <= 0, D_AdEL <= 0.
     - fetch_cnt holds.
  3. stall=0, D_flush=0:
     - F_PC <= nextF.
     - D_PC <= F_PC, D_Instr <= i_inst_rdata, D_valid <= 1, D_AdEL <= F_AdEL.
     - fetch_cnt <= fetch_cnt + 1 (wraps 32'hFFFF_FFFF -> 0).
- Address-error fetch (F_AdEL=1):
  - The instruction is still launched, with D_Instr forced to 0 (nop) instead of i_inst_rdata.
  - D_AdEL=1 carries the exception downstream.
  - F_PC continues to advance normally; exception redirection is outside this block.
- Latency:
  - redirect_PC becomes F_PC one cycle after the accepting edge.
  - Instructions move F->D in one cycle.
- No FSM beyond the PC and F/D registers.

Test Plan:
- Reset, then 3 clocks with stall=0, redirect_en=0, and i_inst_rdata returning the address XOR 32'hA5A5_A5A5:
  - F_PC sequence 3000, 3004, 3008, 300C.
  - D_PC lags F_PC by one cycle.
  - D_Instr matches the data read at that address.
  - fetch_cnt=3.
- Redirect at F_PC=3010 with redirect_PC=3100:
  - Next edge: F_PC=3100, and D_PC=3010 (the delay slot is kept, D_valid=1).
  - Following edge: D_PC=3100.
- stall=1 for 2 cycles with redirect_en=1, redirect_PC=4000, from F_PC=3020:
  - F_PC, D_PC and fetch_cnt are all unchanged.
  - Once stall drops, a redirect held high is taken: F_PC=4000.
- D_flush=1 with stall=0 at F_PC=3030:
  - D_valid=0, D_Instr=0, F_PC=3034, fetch_cnt unchanged.
  - D_flush=1 together with stall=1: everything holds.
- redirect_PC=3002, then redirect_PC=7000:
  - F_AdEL=1 in both cases, and i_inst_addr equals the bad address.
  - After the next edge: D_AdEL=1 and D_Instr=0.
- Assert reset asynchronously between edges while F_PC=3048 with D_valid=1:
  - Outputs immediately return to their reset values.
  - After release, the first edge yields F_PC=3004 and D_PC=3000.
